// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage.
// Issues one instruction-memory read per fetch, captures the word into the
// instruction register and holds it until decode consumes it. It also
// decodes the register fields from ir and pulses pc_adv once per accepted
// instruction. A flush drops any in-flight or held instruction.
// Optional build macro FETCH_TIMEOUT_EN adds a memory wait-cycle watchdog.
// The watchdog raises a sticky fetch_err and abandons the request after
// TIMEOUT_CYCLES cycles without mem_ack.
module instr_fetch #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  input  logic        flush,
  input  logic [15:0] pc_addr,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] ir,
  output logic        ir_valid,
  input  logic        dec_ready,
  output logic [6:0]  opcode,
  output logic [2:0]  dr,
  output logic [2:0]  sa,
  output logic [2:0]  sb,
  output logic [15:0] offset_se,
  output logic        pc_adv,
  output logic        fetch_err
);

  localparam int unsigned XLEN     = 16;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned OFFSET_W = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [XLEN-1:0]   ir_next;
  logic [XLEN-1:0]   mem_addr_next;
  logic              ir_valid_next;
  logic              mem_req_next;
  logic              pc_adv_next;
  logic              timeout_hit;
  logic [OFFSET_W-1:0] offset_raw;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_next;
  logic             fetch_err_next;

  // Watchdog fires on the wait cycle that would make the count reach the limit.
  // A flush in REQ takes precedence, because the request is already being
  // abandoned by moving to DISCARD.
  assign timeout_hit = !mem_ack && (wait_cnt == TIMEOUT_LAST) &&
                       ((state == DISCARD) || ((state == REQ) && !flush));

  // Wait counter: clear on entry to a waiting state, count un-acked wait cycles.
  always_comb begin
    wait_cnt_next  = wait_cnt;
    fetch_err_next = fetch_err;
    if (((state_next == REQ) || (state_next == DISCARD)) && (state_next != state)) begin
      wait_cnt_next = '0;
    end else if (((state == REQ) || (state == DISCARD)) && !mem_ack) begin
      wait_cnt_next = wait_cnt + CNT_W'(1);
    end
    if (timeout_hit) begin
      fetch_err_next = 1'b1;
    end
  end

  // Watchdog registers; fetch_err stays set until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt  <= '0;
      fetch_err <= 1'b0;
    end else begin
      wait_cnt  <= wait_cnt_next;
      fetch_err <= fetch_err_next;
    end
  end
`else
  logic unused_timeout_cfg;

  // Without the watchdog, waiting states never time out.
  assign timeout_hit        = 1'b0;
  assign fetch_err          = 1'b0;
  assign unused_timeout_cfg = ^CNT_W'(TIMEOUT_CYCLES);
`endif

  // Next-state and next-output logic for the fetch FSM.
  always_comb begin
    state_next    = state;
    ir_next       = ir;
    ir_valid_next = ir_valid;
    mem_addr_next = mem_addr;
    pc_adv_next   = 1'b0;

    case (state)
      IDLE: begin
        if (fetch_en && !flush) begin
          state_next    = REQ;
          mem_addr_next = pc_addr;
        end
      end

      REQ: begin
        if (mem_ack) begin
          if (flush) begin
            state_next = IDLE;
          end else begin
            ir_next       = mem_rdata;
            ir_valid_next = 1'b1;
            pc_adv_next   = 1'b1;
            state_next    = HOLD;
          end
        end else if (flush) begin
          state_next = DISCARD;
        end else if (timeout_hit) begin
          state_next = IDLE;
        end
      end

      HOLD: begin
        if (flush) begin
          ir_valid_next = 1'b0;
          state_next    = IDLE;
        end else if (dec_ready) begin
          ir_valid_next = 1'b0;
          if (fetch_en) begin
            state_next    = REQ;
            mem_addr_next = pc_addr;
          end else begin
            state_next = IDLE;
          end
        end
      end

      DISCARD: begin
        if (mem_ack || timeout_hit) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    mem_req_next = (state_next == REQ);
  end

  // State and registered outputs; synchronous reset overrides every input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ir       <= '0;
      ir_valid <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      pc_adv   <= 1'b0;
    end else begin
      state    <= state_next;
      ir       <= ir_next;
      ir_valid <= ir_valid_next;
      mem_req  <= mem_req_next;
      mem_addr <= mem_addr_next;
      pc_adv   <= pc_adv_next;
    end
  end

  // Instruction field decode, straight from ir with no added latency.
  assign opcode     = ir[15:9];
  assign dr         = ir[8:6];
  assign sa         = ir[5:3];
  assign sb         = ir[2:0];
  assign offset_raw = {ir[8:6], ir[2:0]};
  assign offset_se  = {{(XLEN - OFFSET_W){offset_raw[OFFSET_W-1]}}, offset_raw};

`ifndef SYNTHESIS
  // The request line only ever reflects the REQ state.
  a_req_state: assert property (@(posedge clk) disable iff (reset)
    mem_req |-> (state == REQ));

  // The read address never moves under an outstanding request.
  a_addr_stable: assert property (@(posedge clk) disable iff (reset)
    (mem_req && $past(mem_req)) |-> (mem_addr == $past(mem_addr)));

  // A pc advance accompanies a freshly captured instruction.
  a_adv_valid: assert property (@(posedge clk) disable iff (reset)
    pc_adv |-> ir_valid);

  // HOLD always presents a valid instruction to decode.
  a_hold_valid: assert property (@(posedge clk) disable iff (reset)
    (state == HOLD) |-> ir_valid);
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, single fetch with field decode,
// negative offset, decode stall, back-to-back fetch, flushes and watchdog.
module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic        fetch_en;
  logic        flush;
  logic [15:0] pc_addr;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] ir;
  logic        ir_valid;
  logic        dec_ready;
  logic [6:0]  opcode;
  logic [2:0]  dr;
  logic [2:0]  sa;
  logic [2:0]  sb;
  logic [15:0] offset_se;
  logic        pc_adv;
  logic        fetch_err;

  int errors;
  int checks;

  instr_fetch #(.TIMEOUT_CYCLES(15)) dut (
    .clk       (clk),
    .reset     (reset),
    .fetch_en  (fetch_en),
    .flush     (flush),
    .pc_addr   (pc_addr),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .ir        (ir),
    .ir_valid  (ir_valid),
    .dec_ready (dec_ready),
    .opcode    (opcode),
    .dr        (dr),
    .sa        (sa),
    .sb        (sb),
    .offset_se (offset_se),
    .pc_adv    (pc_adv),
    .fetch_err (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; fetch_en = 1'b1; flush = 1'b0; pc_addr = 16'h1234;
    mem_ack = 1'b1; mem_rdata = 16'hFFFF; dec_ready = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({mem_req, ir_valid, pc_adv, fetch_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=0000", {mem_req, ir_valid, pc_adv, fetch_err});
    end
    checks++;
    if (ir !== 16'h0000) begin errors++; $display("FAIL reset_ir got=%h exp=0000", ir); end
    checks++;
    if (mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr got=%h exp=0000", mem_addr); end
    reset = 1'b0; fetch_en = 1'b0; mem_ack = 1'b0;
    tick();
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_idle got=%b exp=0", mem_req); end
  endtask

  task automatic test_basic_fetch();
    fetch_en = 1'b1; pc_addr = 16'h0010;
    tick();
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 16'h0010}) begin
      errors++; $display("FAIL basic_issue got=%b/%h exp=1/0010", mem_req, mem_addr);
    end
    fetch_en = 1'b0; pc_addr = 16'h9999;
    tick();
    checks++;
    if ({mem_req, mem_addr, ir_valid} !== {1'b1, 16'h0010, 1'b0}) begin
      errors++; $display("FAIL basic_wait got=%b/%h/%b exp=1/0010/0", mem_req, mem_addr, ir_valid);
    end
    mem_ack = 1'b1; mem_rdata = 16'h1A5F;
    tick();
    mem_ack = 1'b0;
    checks++;
    if ({ir, ir_valid, pc_adv, mem_req} !== {16'h1A5F, 3'b110}) begin
      errors++; $display("FAIL basic_capture got=%h/%b/%b/%b exp=1a5f/1/1/0", ir, ir_valid, pc_adv, mem_req);
    end
    checks++;
    if ({opcode, dr, sa, sb, offset_se} !== {7'h0D, 3'd1, 3'd3, 3'd7, 16'h000F}) begin
      errors++; $display("FAIL basic_fields got=%h/%0d/%0d/%0d/%h exp=0d/1/3/7/000f", opcode, dr, sa, sb, offset_se);
    end
    tick();
    checks++;
    if ({pc_adv, ir_valid} !== 2'b01) begin
      errors++; $display("FAIL basic_single_adv got=%b/%b exp=0/1", pc_adv, ir_valid);
    end
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    checks++;
    if ({ir_valid, mem_req, ir} !== {2'b00, 16'h1A5F}) begin
      errors++; $display("FAIL basic_consume got=%b/%b/%h exp=0/0/1a5f", ir_valid, mem_req, ir);
    end
  endtask

  task automatic test_neg_offset();
    fetch_en = 1'b1; pc_addr = 16'h0020;
    tick();
    fetch_en = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h01C4;
    tick();
    mem_ack = 1'b0;
    checks++;
    if ({ir, opcode, dr, sa, sb, offset_se} !== {16'h01C4, 7'h00, 3'd7, 3'd0, 3'd4, 16'hFFFC}) begin
      errors++; $display("FAIL neg_offset got=%h/%h/%0d/%0d/%0d/%h exp=01c4/00/7/0/4/fffc", ir, opcode, dr, sa, sb, offset_se);
    end
  endtask

  task automatic test_hold_stall();
    dec_ready = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hBEEF; fetch_en = 1'b1; pc_addr = 16'h0099;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({ir, ir_valid, mem_req, pc_adv} !== {16'h01C4, 3'b100}) begin
        errors++; $display("FAIL hold_stall cyc=%0d got=%h/%b/%b/%b exp=01c4/1/0/0", i, ir, ir_valid, mem_req, pc_adv);
      end
    end
    mem_ack = 1'b0; dec_ready = 1'b1; pc_addr = 16'h0030;
    tick();
    checks++;
    if ({ir_valid, mem_req, mem_addr} !== {2'b01, 16'h0030}) begin
      errors++; $display("FAIL hold_release got=%b/%b/%h exp=0/1/0030", ir_valid, mem_req, mem_addr);
    end
    dec_ready = 1'b0; fetch_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    mem_ack = 1'b1; mem_rdata = 16'h2222;
    tick();
    mem_ack = 1'b0;
    checks++;
    if ({ir, ir_valid, pc_adv} !== {16'h2222, 2'b11}) begin
      errors++; $display("FAIL b2b_first got=%h/%b/%b exp=2222/1/1", ir, ir_valid, pc_adv);
    end
    dec_ready = 1'b1; fetch_en = 1'b1; pc_addr = 16'h0031;
    tick();
    dec_ready = 1'b0; fetch_en = 1'b0;
    checks++;
    if ({mem_req, mem_addr, pc_adv} !== {1'b1, 16'h0031, 1'b0}) begin
      errors++; $display("FAIL b2b_reissue got=%b/%h/%b exp=1/0031/0", mem_req, mem_addr, pc_adv);
    end
    mem_ack = 1'b1; mem_rdata = 16'h3333;
    tick();
    mem_ack = 1'b0;
    checks++;
    if ({ir, ir_valid, pc_adv} !== {16'h3333, 2'b11}) begin
      errors++; $display("FAIL b2b_second got=%h/%b/%b exp=3333/1/1", ir, ir_valid, pc_adv);
    end
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
  endtask

  task automatic test_flush_req();
    fetch_en = 1'b1; pc_addr = 16'h0040;
    tick();
    fetch_en = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if ({mem_req, ir_valid, pc_adv, ir} !== {3'b000, 16'h3333}) begin
      errors++; $display("FAIL flush_discard got=%b/%b/%b/%h exp=0/0/0/3333", mem_req, ir_valid, pc_adv, ir);
    end
    tick(); tick();
    mem_ack = 1'b1; mem_rdata = 16'h4444;
    tick();
    mem_ack = 1'b0;
    checks++;
    if ({ir, ir_valid, pc_adv, mem_req} !== {16'h3333, 3'b000}) begin
      errors++; $display("FAIL flush_drop got=%h/%b/%b/%b exp=3333/0/0/0", ir, ir_valid, pc_adv, mem_req);
    end
    fetch_en = 1'b1; pc_addr = 16'h0050;
    tick();
    fetch_en = 1'b0;
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 16'h0050}) begin
      errors++; $display("FAIL flush_back_idle got=%b/%h exp=1/0050", mem_req, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 16'h5555;
    tick();
    mem_ack = 1'b0;
  endtask

  task automatic test_flush_ack_same();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if ({ir_valid, mem_req, ir} !== {2'b00, 16'h5555}) begin
      errors++; $display("FAIL flush_hold got=%b/%b/%h exp=0/0/5555", ir_valid, mem_req, ir);
    end
    fetch_en = 1'b1; pc_addr = 16'h0060;
    tick();
    fetch_en = 1'b0; flush = 1'b1; mem_ack = 1'b1; mem_rdata = 16'h6666;
    tick();
    flush = 1'b0; mem_ack = 1'b0;
    checks++;
    if ({ir, ir_valid, pc_adv, mem_req} !== {16'h5555, 3'b000}) begin
      errors++; $display("FAIL flush_ack_drop got=%h/%b/%b/%b exp=5555/0/0/0", ir, ir_valid, pc_adv, mem_req);
    end
    fetch_en = 1'b1; pc_addr = 16'h0070;
    tick();
    fetch_en = 1'b0;
    checks++;
    if ({mem_req, mem_addr} !== {1'b1, 16'h0070}) begin
      errors++; $display("FAIL flush_ack_idle got=%b/%h exp=1/0070", mem_req, mem_addr);
    end
  endtask

  task automatic test_reset_mid_req();
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = 16'h7777;
    tick();
    reset = 1'b0; mem_ack = 1'b0;
    checks++;
    if ({ir, ir_valid, mem_req, mem_addr, pc_adv, fetch_err} !== {16'h0000, 2'b00, 16'h0000, 2'b00}) begin
      errors++; $display("FAIL reset_mid_req got=%h/%b/%b/%h/%b/%b exp=0000/0/0/0000/0/0", ir, ir_valid, mem_req, mem_addr, pc_adv, fetch_err);
    end
  endtask

  task automatic test_timeout();
    fetch_en = 1'b1; pc_addr = 16'h0080;
    tick();
    fetch_en = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 14; i++) tick();
    checks++;
    if ({mem_req, fetch_err} !== 2'b10) begin
      errors++; $display("FAIL timeout_before got=%b/%b exp=1/0", mem_req, fetch_err);
    end
    tick();
    checks++;
    if ({mem_req, fetch_err} !== 2'b01) begin
      errors++; $display("FAIL timeout_hit got=%b/%b exp=0/1", mem_req, fetch_err);
    end
    tick(); tick(); tick();
    checks++;
    if ({mem_req, fetch_err} !== 2'b01) begin
      errors++; $display("FAIL timeout_sticky got=%b/%b exp=0/1", mem_req, fetch_err);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (fetch_err !== 1'b0) begin
      errors++; $display("FAIL timeout_reset got=%b exp=0", fetch_err);
    end
`else
    for (int i = 0; i < 40; i++) tick();
    checks++;
    if ({mem_req, mem_addr, fetch_err} !== {1'b1, 16'h0080, 1'b0}) begin
      errors++; $display("FAIL no_timeout got=%b/%h/%b exp=1/0080/0", mem_req, mem_addr, fetch_err);
    end
    mem_ack = 1'b1; mem_rdata = 16'h8888;
    tick();
    mem_ack = 1'b0;
    checks++;
    if ({ir, ir_valid, pc_adv, fetch_err} !== {16'h8888, 3'b110}) begin
      errors++; $display("FAIL no_timeout_ack got=%h/%b/%b/%b exp=8888/1/1/0", ir, ir_valid, pc_adv, fetch_err);
    end
`endif
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic_fetch();
    test_neg_offset();
    test_hold_stall();
    test_back_to_back();
    test_flush_req();
    test_flush_ack_same();
    test_reset_mid_req();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15: memory wait-cycle limit before fetch_err; used only under FETCH_TIMEOUT_EN.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  reset; synchronous, active-high.
REQ-004 fetch_en  input  1  control logic permits a new fetch.
REQ-005 flush  input  1  discard in-flight or held instruction (taken branch/jump).
REQ-006 pc_addr  input  16  current PC value from program counter.
REQ-007 mem_req  output  1  instruction-memory read request.
REQ-008 mem_addr  output  16  read address; stable while mem_req=1.
REQ-009 mem_ack  input  1  memory: mem_rdata valid this cycle.
REQ-010 mem_rdata  input  16  instruction word.
REQ-011 ir  output  16  instruction register.
REQ-012 ir_valid  output  1  ir holds an instruction for decode.
REQ-013 dec_ready  input  1  decode consumes ir this cycle when ir_valid=1.
REQ-014 opcode  output  7  ir[15:9].
REQ-015 dr, sa, sb  output  3 each  ir[8:6], ir[5:3], ir[2:0].
REQ-016 offset_se  output  16  {ir[8:6],ir[2:0]} sign-extended from bit 5 (branch offset for PC).
REQ-017 pc_adv  output  1  one-cycle pulse: control drives PS=01 (PC+1) next cycle.
REQ-018 fetch_err  output  1  sticky memory-timeout flag.

Function
REQ-019 States SHALL be IDLE, REQ, HOLD, DISCARD.
REQ-020 IDLE: fetch_en=1 and flush=0 -> REQ; mem_addr <= pc_addr on that edge.
REQ-021 REQ: mem_req=1, mem_addr held; mem_ack=1 and flush=0 -> ir <= mem_rdata, ir_valid <= 1, pc_adv pulses next cycle, -> HOLD.
REQ-022 REQ with flush=1 and mem_ack=1 same cycle -> data dropped, no pc_adv, -> IDLE.
REQ-023 REQ with flush=1 and mem_ack=0 -> DISCARD; mem_req deasserts; next mem_ack dropped, then -> IDLE.
REQ-024 HOLD: ir_valid=1, ir stable until dec_ready=1.
REQ-025 HOLD with dec_ready=1, flush=0: ir_valid <= 0; fetch_en=1 -> REQ with mem_addr <= pc_addr (back-to-back, one issue per 2 cycles min); else -> IDLE.
REQ-026 HOLD with flush=1 (regardless of dec_ready): ir_valid <= 0, -> IDLE.
REQ-027 Field outputs (opcode..offset_se) SHALL be combinational from ir; zero-latency.
REQ-028 mem_req SHALL be 0 in IDLE, HOLD, DISCARD.
REQ-029 pc_adv SHALL never pulse for a dropped or flushed instruction.
REQ-030 mem_ack outside REQ/DISCARD SHALL be ignored.

Reset
REQ-031 reset=1 SHALL force IDLE, ir=0, ir_valid=0, mem_req=0, mem_addr=0, pc_adv=0, fetch_err=0, timeout counter=0, overriding all other inputs including mid-request.
REQ-032 First fetch after reset deassert SHALL occur no earlier than the cycle after reset falls.

Configuration
REQ-033 Macro FETCH_TIMEOUT_EN defined: 8-bit counter clears on REQ/DISCARD entry, increments each cycle without mem_ack; reaching TIMEOUT_CYCLES -> fetch_err <= 1 (sticky to reset), mem_req drops, -> IDLE.
REQ-034 Macro undefined: no counter, REQ/DISCARD wait indefinitely, fetch_err tied 0.

Verification
REQ-035 Reset then pc_addr=0x0010, fetch_en=1, ack 2 cycles later with 0x1A5F -> mem_addr=0x0010, ir=0x1A5F, opcode=0x0D, dr=1, sa=3, sb=7, offset_se=0x000F, one pc_adv.
REQ-036 ir=0x01C4 (dr=7,sb=4) -> offset_se=0xFFFC.
REQ-037 dec_ready=0 for 5 cycles in HOLD -> ir/ir_valid stable, mem_req=0; dec_ready=1 with fetch_en=1 -> mem_req next cycle.
REQ-038 flush during REQ, ack 3 cycles later -> DISCARD, ir unchanged, ir_valid=0, no pc_adv, IDLE after ack.
REQ-039 FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=15, no ack -> fetch_err=1 after 15 cycles, mem_req=0; reset clears it.
REQ-040 reset asserted mid-REQ with ack same cycle -> all outputs at reset values, ir=0.
